// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_pkg
// Purpose  : Shared constants, state encodings and funct decode for the
//            multi-cycle shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package shift_sequencer_pkg;

    localparam int c_SHAMT_W = 5;

    // EX-stage funct codes
    localparam logic [5:0] c_SLL = 6'b000000;
    localparam logic [5:0] c_SRL = 6'b000010;
    localparam logic [5:0] c_SRA = 6'b000011;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    localparam logic [1:0] c_OP_SLL = 2'd0;
    localparam logic [1:0] c_OP_SRL = 2'd1;
    localparam logic [1:0] c_OP_SRA = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] op;
    } op_dec_t;

    function automatic op_dec_t decode_funct(input logic [5:0] funct);
        op_dec_t d;
        d.valid = 1'b1;
        d.op    = c_OP_SLL;
        case (funct)
            c_SLL:   d.op = c_OP_SLL;
            c_SRL:   d.op = c_OP_SRL;
            c_SRA:   d.op = c_OP_SRA;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_step
// Purpose  : One combinational log-shifter row: shifts by 2^index when
//            enabled, otherwise passes the value through.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_left,
    input  logic             i_fill,
    input  logic [2:0]       i_index,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_value
);
    import shift_sequencer_pkg::*;

    logic [WIDTH-1:0] w_left  [c_SHAMT_W];
    logic [WIDTH-1:0] w_right [c_SHAMT_W];

    for (genvar k = 0; k < c_SHAMT_W; k++) begin : g_stage
        localparam int c_SH = 1 << k;
        assign w_left[k]  = {i_value[WIDTH-1-c_SH:0], {c_SH{i_fill}}};
        assign w_right[k] = {{c_SH{i_fill}}, i_value[WIDTH-1:c_SH]};
    end

    always_comb begin
        o_value = i_value;
        if (i_en) begin
            case (i_index)
                3'd0: o_value = i_left ? w_left[0] : w_right[0];
                3'd1: o_value = i_left ? w_left[1] : w_right[1];
                3'd2: o_value = i_left ? w_left[2] : w_right[2];
                3'd3: o_value = i_left ? w_left[3] : w_right[3];
                3'd4: o_value = i_left ? w_left[4] : w_right[4];
                default: o_value = i_value;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Five-cycle SLL/SRL/SRA controller reusing one shifter row,
//            with pipeline stall, flush and one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);
    import shift_sequencer_pkg::*;

    localparam logic [2:0] c_LAST_STG = 3'(c_SHAMT_W - 1);

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [c_SHAMT_W-1:0] r_amt;
    logic [1:0]           r_op;
    logic                 r_fill;
    logic [2:0]           r_stg;
    logic [WIDTH-1:0]     r_dout;

    op_dec_t              w_dec;
    logic [7:0]           w_amt_ext;
    logic                 w_step_en;
    logic [WIDTH-1:0]     w_step;
    logic                 w_unused_hi;

    assign w_dec       = decode_funct(Signal);
    // Zero-extend so the 3-bit stage counter always indexes in range.
    assign w_amt_ext   = {{(8-c_SHAMT_W){1'b0}}, r_amt};
    assign w_step_en   = w_amt_ext[r_stg];
    assign w_unused_hi = ^dataB[WIDTH-1:c_SHAMT_W];

    shift_sequencer_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_value (r_acc),
        .i_left  (r_op == c_OP_SLL),
        .i_fill  (r_fill),
        .i_index (r_stg),
        .i_en    (w_step_en),
        .o_value (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_acc   <= '0;
            r_amt   <= '0;
            r_op    <= c_OP_SLL;
            r_fill  <= 1'b0;
            r_stg   <= '0;
            r_dout  <= '0;
        end else if (flush) begin
            r_state <= c_S_IDLE;
        end else begin
            case (r_state)
                c_S_SHIFT: begin
                    r_acc <= w_step;
                    r_stg <= r_stg + 3'd1;
                    if (r_stg == c_LAST_STG) begin
                        r_dout  <= w_step;
                        r_state <= c_S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept, so back-to-back requests lose no cycle.
                    if (start) begin
                        if (w_dec.valid) begin
                            r_acc   <= dataA;
                            r_amt   <= dataB[c_SHAMT_W-1:0];
                            r_op    <= w_dec.op;
                            r_fill  <= (w_dec.op == c_OP_SRA) ? dataA[WIDTH-1] : 1'b0;
                            r_stg   <= '0;
                            r_state <= c_S_SHIFT;
                        end else begin
                            r_dout  <= '0;
                            r_state <= c_S_DONE;
                        end
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (r_state == c_S_SHIFT);
    assign stall   = (r_state == c_S_SHIFT);
    assign done    = (r_state == c_S_DONE);
    assign dataOut = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Scoreboard bench for shift_sequencer with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] dataOut;

    shift_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .flush   (flush),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          out_edge;
        bit          shifts;
    } exp_t;

    exp_t        q[$];
    int          cyc       = 0;
    int          next_free = 0;
    logic [31:0] last_res  = '0;
    bit          armed     = 1'b0;
    int          n_checks  = 0;
    int          n_err     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain SystemVerilog shift operators on the captured request.
    task automatic model_edge(input bit r, input bit st, input bit fl,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [5:0] sig);
        exp_t e;
        int   s;
        if (r) begin
            q.delete();
            last_res  = '0;
            next_free = cyc + 1;
        end else if (fl) begin
            while (q.size() > 0 && q[q.size()-1].out_edge >= cyc) void'(q.pop_back());
            next_free = cyc + 1;
        end else if (st && cyc >= next_free) begin
            s = int'(b[4:0]);
            e.shifts = 1'b1;
            case (sig)
                6'b000000: e.res = a << s;
                6'b000010: e.res = a >> s;
                6'b000011: e.res = 32'($signed(a) >>> s);
                default: begin
                    e.res    = '0;
                    e.shifts = 1'b0;
                end
            endcase
            e.out_edge = e.shifts ? cyc + 5 : cyc;
            next_free  = e.out_edge + 1;
            q.push_back(e);
        end
    endtask

    task automatic drive(input bit r, input bit st, input bit fl,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] sig);
        rst = r; start = st; flush = fl; dataA = a; dataB = b; Signal = sig;
        @(posedge clk);
        cyc++;
        model_edge(r, st, fl, a, b, sig);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 32'hDEAD_BEEF, 32'h0, 6'b0);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (q.size() == 0) break;
            idle(1);
        end
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout at edge %0d: got %0d pending expected 0", cyc, q.size());
            q.delete();
        end
    endtask

    task automatic req(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        drive(0, 1, 0, a, b, sig);
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on done.
    always @(negedge clk) begin
        if (armed) begin
            bit exp_busy;
            exp_busy = (q.size() > 0) && q[0].shifts && (q[0].out_edge > cyc);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("stall", 32'(stall), 32'(exp_busy));
            if (done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_done at edge %0d: got done=1 expected done=0", cyc);
                end else begin
                    chk("done_edge", 32'(done ? cyc : 0), 32'(q[0].out_edge));
                    chk("result", dataOut, q[0].res);
                    last_res = q[0].res;
                    void'(q.pop_front());
                end
            end else begin
                if (q.size() > 0 && q[0].out_edge <= cyc) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL missing_done at edge %0d: got done=0 expected done=1", cyc);
                    last_res = q[0].res;
                    void'(q.pop_front());
                end
                chk("dataOut_hold", dataOut, last_res);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at edge %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; start = 0; flush = 0; dataA = '0; dataB = '0; Signal = '0;
        #1;
        drive(1, 0, 0, 32'h0, 32'h0, 6'b0);
        armed = 1'b1;
        drive(1, 0, 0, 32'h0, 32'h0, 6'b0);
        idle(2);

        // Directed cases
        req(6'b000010, 32'hF000_0000, 32'd4);       wait_drain(12);
        req(6'b000011, 32'h8000_0000, 32'd31);      wait_drain(12);
        req(6'b000000, 32'h0000_0001, 32'hFFFF_FFFF); wait_drain(12);
        req(6'b000000, 32'h1234_5678, 32'h0);       wait_drain(12);
        req(6'b000010, 32'h1234_5678, 32'hFFFF_FFE0); wait_drain(12);

        // Back-to-back: start held high; pulses during SHIFT are ignored
        for (int i = 0; i < 7; i++)
            drive(0, 1, 0, (i < 6) ? 32'hA5A5_0F0F : 32'h8765_4321, (i < 6) ? 32'd3 : 32'd9,
                  (i < 6) ? 6'b000000 : 6'b000011);
        wait_drain(12);

        // Flush at the third SHIFT cycle, then flush with start in IDLE
        req(6'b000000, 32'h0000_00FF, 32'd8);
        idle(2);
        drive(0, 0, 1, 32'h0, 32'h0, 6'b0);
        drive(0, 1, 1, 32'h1111_1111, 32'd1, 6'b000010);
        idle(8);
        wait_drain(12);

        // Unsupported funct
        req(6'b100000, 32'hFFFF_FFFF, 32'd1);       wait_drain(4);
        idle(2);

        // Reset mid-SHIFT, then a normal request
        req(6'b000010, 32'hFFFF_0000, 32'd16);
        idle(2);
        drive(1, 0, 0, 32'h0, 32'h0, 6'b0);
        idle(1);
        req(6'b000011, 32'hF000_000F, 32'd2);       wait_drain(12);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            int          k;
            logic [5:0]  sig;
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: sig = 6'b000000;
                3, 4, 5: sig = 6'b000010;
                6, 7, 8: sig = 6'b000011;
                default: sig = 6'($urandom);
            endcase
            drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 4, $urandom, $urandom, sig);
        end
        idle(1);
        wait_drain(12);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
